// File: rtl/rv_dmem_if.sv
// ============================================================================
//  Module      : rv_dmem_if
//  Description : Core-to-data-memory load/store handshake bundle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rv_dmem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, err, busy, rd_count, wr_count
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, err, busy, rd_count, wr_count
    );
endinterface

`default_nettype wire

// File: rtl/rv_dmem_resp.sv
// ============================================================================
//  Module      : rv_dmem_resp
//  Description : Word-organised data-memory responder with fixed wait states,
//                error flagging and wrapping debug access counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv_dmem_resp #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          RD_LAT      = 2,
    parameter int          WR_LAT      = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  wire logic  clk,
    input  wire logic  rst,
    rv_dmem_if.slave   bus
);

    localparam int          IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_span = 32'(DEPTH_WORDS * 4);

    if ((RD_LAT < 1) || (RD_LAT > 15)) begin : g_bad_rd_lat
        $fatal(1, "rv_dmem_resp: RD_LAT must be in 1..15");
    end
    if ((WR_LAT < 1) || (WR_LAT > 15)) begin : g_bad_wr_lat
        $fatal(1, "rv_dmem_resp: WR_LAT must be in 1..15");
    end
    if ((DEPTH_WORDS < 4) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "rv_dmem_resp: DEPTH_WORDS must be a power of two >= 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic               r_we;
    logic               r_err;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic [15:0]        r_rd_count;
    logic [15:0]        r_wr_count;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic [31:0]        w_offset;
    logic               w_bad;
    logic               w_capture;
    logic               w_access;
    logic               w_ready;
    logic               w_err;
    logic               w_busy;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap to huge offsets.
    assign w_offset  = bus.addr - BASE_ADDR;
    assign w_bad     = (bus.addr[1:0] != 2'b00) || (w_offset >= c_span);
    assign w_capture = (r_state == ST_IDLE) && bus.req;
    assign w_access  = (r_state == ST_WAIT) && (r_cnt == 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_err       = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    w_state_nxt = w_bad ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_busy      = 1'b1;
                w_ready     = 1'b1;
                w_err       = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
        end else if (w_capture) begin
            r_we    <= bus.we;
            r_idx   <= w_offset[IDX_W+1:2];
            r_wdata <= bus.wdata;
            r_err   <= w_bad;
            r_cnt   <= bus.we ? 4'(WR_LAT) : 4'(RD_LAT);
            // A failed read presents zero in its ready cycle and keeps it.
            if (w_bad && !bus.we) begin
                r_rdata <= 32'd0;
            end
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
            if (w_access) begin
                if (r_we) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end else begin
                    r_rdata    <= r_mem[r_idx];
                    r_rd_count <= r_rd_count + 16'd1;
                end
            end
        end
    end

    // The array is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_access && r_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign bus.rdata    = r_rdata;
    assign bus.ready    = w_ready;
    assign bus.err      = w_err;
    assign bus.busy     = w_busy;
    assign bus.rd_count = r_rd_count;
    assign bus.wr_count = r_wr_count;

endmodule

`default_nettype wire

// File: tb/tb_rv_dmem_resp.sv
// ============================================================================
//  Module      : tb_rv_dmem_resp
//  Description : Scoreboard bench for rv_dmem_resp (two latency configurations).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv_dmem_resp;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    rv_dmem_if bus_a ();
    rv_dmem_if bus_b ();

    rv_dmem_resp dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    rv_dmem_resp #(.RD_LAT(3), .WR_LAT(4)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] rd_a = 16'd0, wr_a = 16'd0, rd_b = 16'd0, wr_b = 16'd0;

    task automatic drive(input bit b, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (b) begin
            bus_b.req = req; bus_b.we = we; bus_b.addr = addr; bus_b.wdata = wdata;
        end else begin
            bus_a.req = req; bus_a.we = we; bus_a.addr = addr; bus_a.wdata = wdata;
        end
    endtask

    task automatic sample(input bit b, output logic rdy, output logic e, output logic bz,
                          output logic [31:0] rd, output logic [15:0] rdc, output logic [15:0] wrc);
        if (b) begin
            rdy = bus_b.ready; e = bus_b.err; bz = bus_b.busy;
            rd = bus_b.rdata; rdc = bus_b.rd_count; wrc = bus_b.wr_count;
        end else begin
            rdy = bus_a.ready; e = bus_a.err; bz = bus_a.busy;
            rd = bus_a.rdata; rdc = bus_a.rd_count; wrc = bus_a.wr_count;
        end
    endtask

    // Drives one request in cycle 0 and reports the cycle in which ready was seen (-1 on timeout).
    task automatic run_txn(input bit b, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit drop,
                           output int lat, output logic err, output logic [31:0] rdata,
                           output logic busy1);
        logic rdy, e, bz;
        logic [31:0] rd;
        logic [15:0] rdc, wrc;
        @(posedge clk); #1;
        drive(b, 1'b1, we, addr, wdata);
        lat = -1; err = 1'b0; rdata = 32'd0; busy1 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            sample(b, rdy, e, bz, rd, rdc, wrc);
            if (k == 1) begin
                busy1 = bz;
                if (drop) drive(b, 1'b0, ~we, addr ^ 32'h4, ~wdata);
            end
            if (rdy) begin
                lat = k; err = e; rdata = rd;
                break;
            end
        end
        drive(b, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset;
        logic rdy, e, bz;
        logic [31:0] rd;
        logic [15:0] rdc, wrc;
        rst_a = 1'b1; rst_b = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        sample(0, rdy, e, bz, rd, rdc, wrc);
        checks++; if (rdy !== 1'b0)     begin errors++; $display("FAIL reset_ready got %b exp 0", rdy); end
        checks++; if (e !== 1'b0)       begin errors++; $display("FAIL reset_err got %b exp 0", e); end
        checks++; if (bz !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", bz); end
        checks++; if (rd !== 32'd0)     begin errors++; $display("FAIL reset_rdata got %h exp 0", rd); end
        checks++; if (rdc !== 16'd0)    begin errors++; $display("FAIL reset_rd_count got %h exp 0", rdc); end
        checks++; if (wrc !== 16'd0)    begin errors++; $display("FAIL reset_wr_count got %h exp 0", wrc); end
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    task automatic test_write_read;
        int lat; logic e, b1, rdy, bz; logic [31:0] rd; logic [15:0] rdc, wrc; exp_t x;
        sb.push_back('{2, 1'b0, 1'b0, 32'd0});
        run_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, lat, e, rd, b1);
        x = sb.pop_front(); wr_a++;
        checks++; if (lat !== x.lat) begin errors++; $display("FAIL wr_latency got %0d exp %0d", lat, x.lat); end
        checks++; if (e !== x.err)   begin errors++; $display("FAIL wr_err got %b exp %b", e, x.err); end
        checks++; if (b1 !== 1'b1)   begin errors++; $display("FAIL wr_busy_c1 got %b exp 1", b1); end
        sb.push_back('{3, 1'b0, 1'b1, 32'hDEAD_BEEF});
        run_txn(0, 1'b0, 32'h10, 32'd0, 1'b0, lat, e, rd, b1);
        x = sb.pop_front(); rd_a++;
        checks++; if (lat !== x.lat)  begin errors++; $display("FAIL rd_latency got %0d exp %0d", lat, x.lat); end
        checks++; if (e !== x.err)    begin errors++; $display("FAIL rd_err got %b exp %b", e, x.err); end
        checks++; if (rd !== x.rdata) begin errors++; $display("FAIL rd_data got %h exp %h", rd, x.rdata); end
        sample(0, rdy, e, bz, rd, rdc, wrc);
        checks++; if (rdc !== rd_a) begin errors++; $display("FAIL wr_rd_count got %h exp %h", rdc, rd_a); end
        checks++; if (wrc !== wr_a) begin errors++; $display("FAIL wr_wr_count got %h exp %h", wrc, wr_a); end
    endtask

    task automatic test_errors;
        int lat; logic e, b1, rdy, bz; logic [31:0] rd; logic [15:0] rdc, wrc; exp_t x;
        run_txn(0, 1'b1, 32'h0, 32'h1111_2222, 1'b0, lat, e, rd, b1);
        wr_a++;
        sb.push_back('{1, 1'b1, 1'b1, 32'd0});
        run_txn(0, 1'b0, 32'h13, 32'd0, 1'b0, lat, e, rd, b1);
        x = sb.pop_front();
        checks++; if (lat !== x.lat)  begin errors++; $display("FAIL misalign_latency got %0d exp %0d", lat, x.lat); end
        checks++; if (e !== x.err)    begin errors++; $display("FAIL misalign_err got %b exp %b", e, x.err); end
        checks++; if (rd !== x.rdata) begin errors++; $display("FAIL misalign_rdata got %h exp %h", rd, x.rdata); end
        sb.push_back('{1, 1'b1, 1'b0, 32'd0});
        run_txn(0, 1'b1, 32'h400, 32'h5555_5555, 1'b0, lat, e, rd, b1);
        x = sb.pop_front();
        checks++; if (lat !== x.lat) begin errors++; $display("FAIL range_latency got %0d exp %0d", lat, x.lat); end
        checks++; if (e !== x.err)   begin errors++; $display("FAIL range_err got %b exp %b", e, x.err); end
        sample(0, rdy, e, bz, rd, rdc, wrc);
        checks++; if (rdc !== rd_a) begin errors++; $display("FAIL err_rd_count got %h exp %h", rdc, rd_a); end
        checks++; if (wrc !== wr_a) begin errors++; $display("FAIL err_wr_count got %h exp %h", wrc, wr_a); end
        sb.push_back('{3, 1'b0, 1'b1, 32'h1111_2222});
        run_txn(0, 1'b0, 32'h0, 32'd0, 1'b0, lat, e, rd, b1);
        x = sb.pop_front(); rd_a++;
        checks++; if (rd !== x.rdata) begin errors++; $display("FAIL range_no_alias got %h exp %h", rd, x.rdata); end
        checks++; if (e !== x.err)    begin errors++; $display("FAIL range_no_alias_err got %b exp %b", e, x.err); end
    endtask

    task automatic test_req_drop;
        int lat, spurious; logic e, b1, rdy, bz; logic [31:0] rd; logic [15:0] rdc, wrc; exp_t x;
        run_txn(0, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, lat, e, rd, b1);
        wr_a++;
        sb.push_back('{3, 1'b0, 1'b1, 32'hCAFE_F00D});
        run_txn(0, 1'b0, 32'h20, 32'd0, 1'b1, lat, e, rd, b1);
        x = sb.pop_front(); rd_a++;
        checks++; if (lat !== x.lat)  begin errors++; $display("FAIL drop_latency got %0d exp %0d", lat, x.lat); end
        checks++; if (rd !== x.rdata) begin errors++; $display("FAIL drop_rdata got %h exp %h", rd, x.rdata); end
        spurious = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            sample(0, rdy, e, bz, rd, rdc, wrc);
            if (rdy || bz) spurious++;
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL drop_spurious got %0d exp 0", spurious); end
        checks++; if (rdc !== rd_a)   begin errors++; $display("FAIL drop_rd_count got %h exp %h", rdc, rd_a); end
    endtask

    task automatic test_back_to_back;
        logic rdy, e, bz; logic [31:0] rd; logic [15:0] rdc, wrc; exp_t x; int n;
        sb.push_back('{2, 1'b0, 1'b0, 32'd0});
        sb.push_back('{6, 1'b0, 1'b1, 32'h600D_CAFE});
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h30, 32'h600D_CAFE);
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            sample(0, rdy, e, bz, rd, rdc, wrc);
            if (k == 3) begin
                checks++; if (bz !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", bz); end
            end
            if (rdy) begin
                x = sb.pop_front(); n++;
                checks++; if (k !== x.lat) begin errors++; $display("FAIL b2b_latency%0d got %0d exp %0d", n, k, x.lat); end
                checks++; if (e !== x.err) begin errors++; $display("FAIL b2b_err%0d got %b exp %b", n, e, x.err); end
                if (x.chk_rd) begin
                    checks++; if (rd !== x.rdata) begin errors++; $display("FAIL b2b_rdata got %h exp %h", rd, x.rdata); end
                end
                if (n == 1) drive(0, 1'b1, 1'b0, 32'h30, 32'd0);
                else begin drive(0, 1'b0, 1'b0, 32'd0, 32'd0); break; end
            end
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL b2b_missing got %0d pending exp 0", sb.size()); end
        sb.delete();
        wr_a++; rd_a++;
    endtask

    task automatic test_reset_midwrite;
        int lat; logic e, b1, rdy, bz; logic [31:0] rd; logic [15:0] rdc, wrc; exp_t x;
        run_txn(1, 1'b1, 32'h08, 32'hAAAA_AAAA, 1'b0, lat, e, rd, b1);
        wr_b++;
        checks++; if (lat !== 5) begin errors++; $display("FAIL b_wr_latency got %0d exp 5", lat); end
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 32'h08, 32'h1234_5678);
        repeat (2) @(posedge clk);
        #1;
        sample(1, rdy, e, bz, rd, rdc, wrc);
        checks++; if (bz !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b exp 1", bz); end
        rst_b = 1'b1;
        #1;
        sample(1, rdy, e, bz, rd, rdc, wrc);
        wr_b = 16'd0;
        checks++; if (bz !== 1'b0)   begin errors++; $display("FAIL rst_busy got %b exp 0", bz); end
        checks++; if (rdy !== 1'b0)  begin errors++; $display("FAIL rst_ready got %b exp 0", rdy); end
        checks++; if (wrc !== wr_b)  begin errors++; $display("FAIL rst_wr_count got %h exp %h", wrc, wr_b); end
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        rst_b = 1'b0;
        sb.push_back('{4, 1'b0, 1'b1, 32'hAAAA_AAAA});
        run_txn(1, 1'b0, 32'h08, 32'd0, 1'b0, lat, e, rd, b1);
        x = sb.pop_front(); rd_b++;
        checks++; if (lat !== x.lat)  begin errors++; $display("FAIL rst_rd_latency got %0d exp %0d", lat, x.lat); end
        checks++; if (rd !== x.rdata) begin errors++; $display("FAIL rst_keeps_array got %h exp %h", rd, x.rdata); end
        sample(1, rdy, e, bz, rd, rdc, wrc);
        checks++; if (wrc !== wr_b) begin errors++; $display("FAIL rst_wr_count_after got %h exp %h", wrc, wr_b); end
        checks++; if (rdc !== rd_b) begin errors++; $display("FAIL rst_rd_count_after got %h exp %h", rdc, rd_b); end
    endtask

    task automatic test_wrap;
        int lat; logic e, b1, rdy, bz; logic [31:0] rd; logic [15:0] rdc, wrc; exp_t x;
        // Counter preloaded two reads short of wrap instead of issuing 65534 real reads.
        @(negedge clk);
        dut_a.r_rd_count = 16'hFFFE;
        rd_a = 16'hFFFE;
        sb.push_back('{3, 1'b0, 1'b1, 32'hDEAD_BEEF});
        run_txn(0, 1'b0, 32'h10, 32'd0, 1'b0, lat, e, rd, b1);
        x = sb.pop_front(); rd_a++;
        sample(0, rdy, e, bz, rd, rdc, wrc);
        checks++; if (rdc !== rd_a) begin errors++; $display("FAIL wrap_ffff got %h exp %h", rdc, rd_a); end
        sb.push_back('{3, 1'b0, 1'b1, 32'hCAFE_F00D});
        run_txn(0, 1'b0, 32'h20, 32'd0, 1'b0, lat, e, rd, b1);
        x = sb.pop_front(); rd_a++;
        checks++; if (rd !== x.rdata) begin errors++; $display("FAIL wrap_rdata got %h exp %h", rd, x.rdata); end
        sample(0, rdy, e, bz, rd, rdc, wrc);
        checks++; if (rdc !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", rdc); end
        checks++; if (wrc !== wr_a)     begin errors++; $display("FAIL wrap_wr_count got %h exp %h", wrc, wr_a); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_req_drop();
        test_back_to_back();
        test_reset_midwrite();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
